// File: rtl/pipo_rr_loader.sv
// Round-robin arbiter feeding one shared PIPO holding register.
// One requester is granted per load; the captured word is offered downstream with valid/ready.
module pipo_rr_loader #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_src
);

  // Handshake: a word is consumed on any edge where out_valid && out_ready;
  // out_data/out_src stay stable while out_valid && !out_ready.

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [SW:0] NREQ_X = (SW+1)'(NREQ);

  state_t        state, state_nxt;
  logic [SW-1:0] ptr, ptr_nxt, winner;
  logic [SW:0]   idx;
  logic          found, load_ok, grant;
  logic [W-1:0]  win_data;

  // Circular search from ptr; explicit modulo keeps non-power-of-two NREQ correct.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (SW+1)'(i);
      if (idx >= NREQ_X) idx = idx - NREQ_X;
      if (!found && req[idx[SW-1:0]]) begin
        found  = 1'b1;
        winner = idx[SW-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (winner == SW'(j)) win_data = wdata[j*W +: W];
    end
  end

  assign load_ok = (state == IDLE) || out_ready;
  assign grant   = load_ok && found && !rst;
  assign ptr_nxt = (winner == SW'(NREQ-1)) ? '0 : winner + 1'b1;

  always_comb begin
    gnt = '0;
    for (int j = 0; j < NREQ; j++) begin
      gnt[j] = grant && (winner == SW'(j));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = HOLD;
      HOLD:    if (out_ready && !grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        out_data <= win_data;
        out_src  <= winner;
        ptr      <= ptr_nxt;
      end
    end
  end

  assign out_valid = (state == HOLD);

endmodule

// File: doc/pipo_rr_loader.md
Name: pipo_rr_loader

Overview:
- Round-robin arbiter and load controller for a shared parallel-in parallel-out holding register.
- NREQ requesters each present a W-bit word.
- The block grants one requester per load, captures its word into the internal PIPO register, and presents it downstream with a valid/ready handshake.
- It sits between several producer blocks and a single consumer that shares one register stage.

Parameters:
- W, 4, data width of each requester word and of the holding register.
- NREQ, 4, number of requesters, minimum 2.
- SW, $clog2(NREQ), width of the source index. Derived; do not override.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester load request. Level; held until granted.
- wdata  input  NREQ*W  flattened requester words. Requester i occupies bits [i*W +: W].
- gnt  output  NREQ  one-hot grant, combinational. Bit i high means requester i's word is captured at this rising edge.
- out_valid  output  1  holding register contains an unconsumed word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  W  holding register contents.
- out_src  output  SW  index of the requester that supplied out_data.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out_valid=0, out_data=0, out_src=0, rr pointer=0, state=IDLE.
  - gnt forced to 0 while rst is high.
  - A word pending at reset is discarded.
- States:
  - IDLE: holding register empty.
  - HOLD: out_valid=1.
- load_ok:
  - =1 in IDLE.
  - =1 in HOLD when out_ready=1.
  - Otherwise 0.
- Grant selection:
  - When load_ok and req!=0, the winner is the first requester with req=1, searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - gnt = one-hot(winner). Otherwise gnt=0.
  - gnt never has more than one bit set.
- At the rising edge with a grant:
  - out_data <= wdata[winner].
  - out_src <= winner.
  - out_valid <= 1.
  - ptr <= (winner+1) mod NREQ.
  - state <= HOLD.
- HOLD with out_ready=1 and req==0: out_valid <= 0, state <= IDLE. out_data and out_src keep their last value.
- HOLD with out_ready=1 and a grant: back-to-back. The consumed word is replaced by the new word at the same edge, out_valid stays 1, and state stays HOLD.
- HOLD with out_ready=0:
  - out_data, out_src and out_valid are held stable.
  - gnt=0.
  - ptr unchanged.
- IDLE with out_ready=1: ignored, no state change.
- Latency:
  - Captured word visible on out_data one cycle after its grant edge.
  - Sustained throughput is one word per cycle while out_ready=1 and requests are pending.
- Fairness:
  - A continuously requesting requester is granted within NREQ loads.
  - The pointer moves only on a grant.
- Requester protocol:
  - A requester samples gnt at the clock edge and may deassert or change req/wdata in the following cycle.
  - A requester that drops req before being granted simply loses its turn, with no side effects.
- The ptr wrap from NREQ-1 to 0 is required. Handle non-power-of-two NREQ with an explicit modulo, not truncation.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, out_valid=0, out_data=0, out_src=0 throughout.
- req=4'b0100, wdata[2]=4'hA, out_ready=1 -> gnt=4'b0100 for one cycle. Next cycle out_valid=1, out_data=A, out_src=2. The cycle after, out_valid=0. ptr=3.
- All four requesting continuously with words 1,2,3,4 for requesters 0..3, out_ready=1 from reset -> grant order 0,1,2,3,0 on consecutive cycles. out_data sequence is 1,2,3,4,1 with out_valid continuously 1.
- Backpressure:
  - Sequence: load word 5 from requester 1, hold out_ready=0 for 4 cycles while req=4'b1001.
  - Required: out_data=5 and out_src=1 stable, gnt=0 during the stall.
  - Then raise out_ready: requester 3 is granted (ptr=2), out_data=requester 3's word.
- Wrap: ptr=3, req=4'b1001 -> requester 3 granted, ptr wraps to 0. Next load grants requester 0.
- Assert rst mid-HOLD with out_valid=1, out_data=7 -> out_valid=0, out_data=0 and gnt=0 immediately, without waiting for a clock edge. After release, a load from requester 1 with req=4'b1010 goes first (ptr=0).
